// File: rtl/universal_register_pkg.sv
// Mode encodings and widths shared by the universal register and its bench.
package universal_register_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROTL = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROTR = 3'b101;
  localparam logic [MODE_W-1:0] MODE_INC  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_DEC  = 3'b111;

endpackage

// File: rtl/ur_dff_bank.sv
// WIDTH-bit flop bank with asynchronous active-low reset to RESET_VAL and a load enable.
module ur_dff_bank #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RESET_VAL;
    end else if (load_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/universal_register.sv
// Multi-mode N-bit working register: hold/load/shift/rotate/inc/dec with a registered carry flag.
// Optional synchronous clear port enabled by defining UNIVERSAL_REGISTER_SYNC_CLEAR_EN.
module universal_register
  import universal_register_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter logic [63:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef UNIVERSAL_REGISTER_SYNC_CLEAR_EN
  input  logic              clr,
`endif
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin_l,
  input  logic              sin_r,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qbar,
  output logic              carry_out,
  output logic              zero
);

  localparam logic [WIDTH:0] One = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   sum;
  logic             load;

  always_comb begin
    q_d     = q_q;
    carry_d = carry_q;
    sum     = '0;
    case (mode)
      MODE_LOAD: begin
        q_d     = d;
        carry_d = 1'b0;
      end
      MODE_SHL: begin
        q_d     = {q_q[WIDTH-2:0], sin_r};
        carry_d = q_q[WIDTH-1];
      end
      MODE_SHR: begin
        q_d     = {sin_l, q_q[WIDTH-1:1]};
        carry_d = q_q[0];
      end
      MODE_ROTL: begin
        q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        carry_d = q_q[WIDTH-1];
      end
      MODE_ROTR: begin
        q_d     = {q_q[0], q_q[WIDTH-1:1]};
        carry_d = q_q[0];
      end
      // Extra MSB of the W+1-bit result is the carry (inc) or borrow (dec).
      MODE_INC: begin
        sum     = {1'b0, q_q} + One;
        q_d     = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
      end
      MODE_DEC: begin
        sum     = {1'b0, q_q} - One;
        q_d     = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
      end
      default: ;
    endcase
`ifdef UNIVERSAL_REGISTER_SYNC_CLEAR_EN
    if (clr) begin
      q_d     = '0;
      carry_d = 1'b0;
    end
`endif
  end

`ifdef UNIVERSAL_REGISTER_SYNC_CLEAR_EN
  assign load = en | clr;
`else
  assign load = en;
`endif

  ur_dff_bank #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL[WIDTH-1:0])
  ) u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .d_i    (q_d),
    .q_o    (q_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (load) begin
      carry_q <= carry_d;
    end
  end

  assign q         = q_q;
  assign qbar      = ~q_q;
  assign carry_out = carry_q;
  assign zero      = (q_q == '0);

endmodule

// File: tb/tb_universal_register.sv
// Bench for universal_register (WIDTH=8, RESET_VAL=0): directed vector table plus random
// stimulus checked against an arithmetic reference model.
module tb_universal_register;
  import universal_register_pkg::*;

  localparam int W = 8;
  localparam int M = 256;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [2:0]   mode = MODE_HOLD;
  logic [W-1:0] d = '0;
  logic         sin_l = 1'b0;
  logic         sin_r = 1'b0;
  logic [W-1:0] q, qbar;
  logic         carry_out, zero;
`ifdef UNIVERSAL_REGISTER_SYNC_CLEAR_EN
  logic         clr = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  universal_register #(
    .WIDTH     (W),
    .RESET_VAL (64'd0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef UNIVERSAL_REGISTER_SYNC_CLEAR_EN
    .clr       (clr),
`endif
    .en        (en),
    .mode      (mode),
    .d         (d),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .q         (q),
    .qbar      (qbar),
    .carry_out (carry_out),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_l;
    logic       sin_r;
    logic [7:0] exp_q;
    logic       exp_c;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input int eq, input int ec);
    check({name, ".q"}, 64'(q), 64'(eq));
    check({name, ".qbar"}, 64'(qbar), 64'((~eq) & (M - 1)));
    check({name, ".carry"}, 64'(carry_out), 64'(ec));
    check({name, ".zero"}, 64'(zero), 64'(eq == 0));
  endtask

  task automatic step(input logic e, input logic [2:0] m, input logic [7:0] dd,
                      input logic sl, input logic sr);
    en = e; mode = m; d = dd; sin_l = sl; sin_r = sr;
    @(posedge clk);
    #1;
  endtask

  // Reference model: register state as plain integers, rules as arithmetic.
  int mq = 0;
  int mc = 0;

  task automatic model(input logic e, input logic [2:0] m, input int dd, input int sl,
                       input int sr);
    int oq;
    oq = mq;
    if (!e) return;
    case (m)
      MODE_LOAD: begin mq = dd; mc = 0; end
      MODE_SHL:  begin mq = (oq * 2 + sr) % M;           mc = (oq >= M / 2) ? 1 : 0; end
      MODE_SHR:  begin mq = oq / 2 + sl * (M / 2);       mc = oq % 2; end
      MODE_ROTL: begin mq = (oq * 2) % M + oq / (M / 2); mc = (oq >= M / 2) ? 1 : 0; end
      MODE_ROTR: begin mq = oq / 2 + (oq % 2) * (M / 2); mc = oq % 2; end
      MODE_INC:  begin mq = (oq + 1) % M;                mc = (oq == M - 1) ? 1 : 0; end
      MODE_DEC:  begin mq = (oq + M - 1) % M;            mc = (oq == 0) ? 1 : 0; end
      default: ;
    endcase
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0});
    vecs.push_back('{1'b0, MODE_LOAD, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0});
    vecs.push_back('{1'b0, MODE_LOAD, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0});
    vecs.push_back('{1'b0, MODE_LOAD, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0});
    vecs.push_back('{1'b1, MODE_SHL,  8'h00, 1'b0, 1'b1, 8'h4B, 1'b1});
    vecs.push_back('{1'b1, MODE_SHR,  8'h00, 1'b0, 1'b0, 8'h25, 1'b1});
    vecs.push_back('{1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0});
    vecs.push_back('{1'b1, MODE_ROTL, 8'h00, 1'b1, 1'b0, 8'h03, 1'b1});
    vecs.push_back('{1'b1, MODE_ROTR, 8'h00, 1'b0, 1'b1, 8'h81, 1'b1});
    vecs.push_back('{1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{1'b1, MODE_INC,  8'h00, 1'b0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{1'b1, MODE_DEC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1});
    vecs.push_back('{1'b1, MODE_HOLD, 8'h12, 1'b1, 1'b1, 8'hFF, 1'b1});
    vecs.push_back('{1'b0, MODE_INC,  8'h12, 1'b1, 1'b1, 8'hFF, 1'b1});
    vecs.push_back('{1'b1, MODE_LOAD, 8'h7F, 1'b0, 1'b0, 8'h7F, 1'b0});
    vecs.push_back('{1'b1, MODE_INC,  8'h00, 1'b0, 1'b0, 8'h80, 1'b0});

    // Power-on reset.
    #2;
    check_all("reset_init", 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sin_l, vecs[i].sin_r);
      check_all($sformatf("vec%0d", i), int'(vecs[i].exp_q), int'(vecs[i].exp_c));
    end

    // Asynchronous reset mid-cycle with carry set beforehand.
    step(1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0);
    step(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b1);
    check_all("pre_reset", 'h4B, 1);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_reset", 0, 0);
    step(1'b1, MODE_LOAD, 8'h66, 1'b0, 1'b0);
    check_all("reset_held", 0, 0);
    #1 rst_n = 1'b1;
    step(1'b1, MODE_LOAD, 8'h5A, 1'b0, 1'b0);
    check_all("first_after_reset", 'h5A, 0);

`ifdef UNIVERSAL_REGISTER_SYNC_CLEAR_EN
    step(1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0);
    step(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
    clr = 1'b1;
    step(1'b1, MODE_LOAD, 8'h55, 1'b0, 1'b0);
    check_all("clr", 0, 0);
    clr = 1'b0;
    step(1'b1, MODE_LOAD, 8'h55, 1'b0, 1'b0);
    check_all("after_clr", 'h55, 0);
    clr = 1'b1;
    step(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);
    check_all("clr_no_en", 0, 0);
    clr = 1'b0;
`endif

    // Random stimulus against the model, starting from a known state.
    step(1'b1, MODE_LOAD, 8'h00, 1'b0, 1'b0);
    mq = 0;
    mc = 0;
    for (int i = 0; i < 400; i++) begin
      logic       e;
      logic [2:0] m;
      logic [7:0] dd;
      logic       sl, sr;
      e  = ($urandom_range(0, 4) != 0);
      m  = 3'($urandom_range(0, 7));
      dd = 8'($urandom_range(0, 255));
      sl = 1'($urandom_range(0, 1));
      sr = 1'($urandom_range(0, 1));
      model(e, m, int'(dd), int'(sl), int'(sr));
      step(e, m, dd, sl, sr);
      check_all($sformatf("rand%0d", i), mq, mc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
